ps2_host_tx: RTL

Host-to-device PS/2 transmitter for the Apple 1 core. It is the complement of the existing PS/2 keyboard receiver and sends command bytes to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable. It drives the open-drain PS/2 clock and data lines through active-high pull-low enables and runs the full host request-to-send sequence, including the device ACK check. It sits beside the receiver in the apple1 core, fed by a small command register, and asserts a busy flag so the receiver ignores the line while a transmit is in progress.

---
 rtl/ps2_host_pkg.sv | 34 +++
 rtl/ps2_line_sync.sv | 35 +++
 rtl/ps2_host_tx.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
package ps2_host_pkg;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned TMR_W      = 19;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    WAIT_FIRST,
    BITS,
    ACK,
    WAIT_IDLE,
    ABORT
  } state_e;

  // Serial frame after the start bit, shifted out LSB first.
  typedef struct packed {
    logic       stop;
    logic       parity;
    logic [7:0] data;
  } ps2_frame_t;

  function automatic ps2_frame_t build_frame(input logic [7:0] data);
    ps2_frame_t f;
    f.stop   = 1'b1;
    f.parity = ~^data;
    f.data   = data;
    return f;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus a clock falling-edge detector.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_din,
  output logic sync_clk,
  output logic sync_dat,
  output logic fall_c
);

  logic clk_meta;
  logic dat_meta;
  logic sync_clk_q;

  // Idle bus level is high, so everything resets to 1 to avoid a phantom edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta   <= 1'b1;
      dat_meta   <= 1'b1;
      sync_clk   <= 1'b1;
      sync_dat   <= 1'b1;
      sync_clk_q <= 1'b1;
    end else begin
      clk_meta   <= ps2_clk;
      dat_meta   <= ps2_din;
      sync_clk   <= clk_meta;
      sync_dat   <= dat_meta;
      sync_clk_q <= sync_clk;
    end
  end

  assign fall_c = sync_clk_q & ~sync_clk;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, clocked-out frame and device ACK check.
module ps2_host_tx
  import ps2_host_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES       = 2500,
  parameter int unsigned START_TIMEOUT_CYCLES = 375000,
  parameter int unsigned BIT_TIMEOUT_CYCLES   = 50000
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_din,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam logic [TMR_W-1:0] INHIBIT_LAST = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] START_LAST   = TMR_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] BIT_LAST     = TMR_W'(BIT_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_BIT     = CNT_W'(FRAME_BITS - 1);

  state_e                 state_q;
  state_e                 state_d;
  logic [FRAME_BITS-1:0]  shreg_q;
  logic [FRAME_BITS-1:0]  shreg_d;
  logic [CNT_W-1:0]       bitcnt_q;
  logic [CNT_W-1:0]       bitcnt_d;
  logic [TMR_W-1:0]       tmr_q;
  logic [TMR_W-1:0]       tmr_d;
  logic [TMR_W-1:0]       tmr_inc_c;
  logic                   tmr_clr_c;
  logic                   dat_oe_d;
  logic                   clk_oe_d;
  logic                   done_d;
  logic                   err_d;
  ps2_frame_t             frame_c;

  logic                   sync_clk;
  logic                   sync_dat;
  logic                   fall_c;

  ps2_line_sync u_sync (
    .clk      (clk25),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_din  (ps2_din),
    .sync_clk (sync_clk),
    .sync_dat (sync_dat),
    .fall_c   (fall_c)
  );

  assign frame_c   = build_frame(tx_data);
  assign tmr_inc_c = (&tmr_q) ? tmr_q : tmr_q + TMR_W'(1);

  // Next-state and next-output logic; every output register is loaded from here.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    dat_oe_d  = ps2_dat_oe;
    done_d    = 1'b0;
    tmr_clr_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        dat_oe_d = 1'b0;
        if (tx_valid) begin
          shreg_d  = frame_c;
          bitcnt_d = '0;
          state_d  = INHIBIT;
        end
      end

      // Device falls here are our own clock pull-down and are ignored.
      INHIBIT: begin
        dat_oe_d = 1'b0;
        if (tmr_q >= INHIBIT_LAST) begin
          state_d  = REQ;
          dat_oe_d = 1'b1;
        end
      end

      REQ: begin
        dat_oe_d = 1'b1;
        state_d  = WAIT_FIRST;
      end

      WAIT_FIRST: begin
        if (fall_c) begin
          dat_oe_d = ~shreg_q[0];
          shreg_d  = shreg_q >> 1;
          bitcnt_d = CNT_W'(1);
          state_d  = BITS;
        end else if (tmr_q >= START_LAST) begin
          state_d = ABORT;
        end
      end

      BITS: begin
        if (fall_c) begin
          tmr_clr_c = 1'b1;
          dat_oe_d  = ~shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bitcnt_d  = bitcnt_q + CNT_W'(1);
          if (bitcnt_q >= LAST_BIT) begin
            state_d = ACK;
          end
        end else if (tmr_q >= BIT_LAST) begin
          state_d = ABORT;
        end
      end

      ACK: begin
        dat_oe_d = 1'b0;
        if (fall_c) begin
          tmr_clr_c = 1'b1;
          state_d   = sync_dat ? ABORT : WAIT_IDLE;
        end else if (tmr_q >= BIT_LAST) begin
          state_d = ABORT;
        end
      end

      WAIT_IDLE: begin
        dat_oe_d = 1'b0;
        if (sync_clk && sync_dat) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (tmr_q >= BIT_LAST) begin
          state_d = ABORT;
        end
      end

      ABORT: begin
        dat_oe_d = 1'b0;
        state_d  = IDLE;
      end

      default: begin
        dat_oe_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    if (state_d == ABORT) begin
      dat_oe_d = 1'b0;
    end
    err_d    = (state_d == ABORT);
    clk_oe_d = (state_d == INHIBIT) || (state_d == REQ);
    tmr_d    = (tmr_clr_c || (state_d != state_q)) ? '0 : tmr_inc_c;
  end

  // State, datapath and registered outputs; reset releases both lines at once.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      tmr_q      <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      tmr_q      <= tmr_d;
      ps2_clk_oe <= clk_oe_d;
      ps2_dat_oe <= dat_oe_d;
      tx_ready   <= (state_d == IDLE);
      tx_busy    <= (state_d != IDLE);
      tx_done    <= done_d;
      tx_err     <= err_d;
    end
  end

endmodule
